// File: rtl/rs_pkg.sv
// Reservation-station shared types: operand/tag/payload widths, entry record, index-width helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rs_pkg;

    localparam int RS_NUM_ENTRIES = 16;
    localparam int RS_NUM_SRC     = 3;
    localparam int RS_NUM_CDB     = 2;
    localparam int RS_DATA_W      = 64;
    localparam int RS_TAG_W       = 7;
    localparam int RS_PAYLOAD_W   = 96;

    typedef logic [RS_TAG_W-1:0]     tag_t;
    typedef logic [RS_DATA_W-1:0]    data_t;
    typedef logic [RS_PAYLOAD_W-1:0] payload_t;

    // One station slot; src_data[s] is only meaningful once src_rdy[s] is set.
    typedef struct packed {
        logic                   valid;
        payload_t               payload;
        tag_t                   dst_tag;
        logic [RS_NUM_SRC-1:0]  src_rdy;
        tag_t [RS_NUM_SRC-1:0]  src_tag;
        data_t [RS_NUM_SRC-1:0] src_data;
    } rs_entry_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix: tracks relative allocation order of station slots and picks the oldest eligible one.
// Latency: o_oldest is combinational from the registered matrix and i_elig; updates land at the edge.
// Backpressure: none; alloc/free are already-qualified one-hot/bit vectors from the station.
// Ports: i_clock/i_reset (async high), i_alloc one-hot slot written this cycle, i_free slots released,
//        i_valid current slot valid bits, i_elig eligible slots, o_oldest one-hot oldest eligible (or 0).
module rs_age_matrix #(
    parameter int N = 16
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic [N-1:0] i_alloc,
    input  logic [N-1:0] i_free,
    input  logic [N-1:0] i_valid,
    input  logic [N-1:0] i_elig,
    output logic [N-1:0] o_oldest
);

    // r_older[i][j] = 1 means slot i was allocated before slot j.
    // Bits touching invalid slots may go stale; they are rewritten on reallocation
    // and never consulted because only eligible (hence valid) slots are compared.
    logic [N-1:0] r_older [N];

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < N; i++) r_older[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (i_alloc[i] || i_free[i] || i_free[j])
                        r_older[i][j] <= 1'b0;
                    else if (i_alloc[j] && i_valid[i])
                        r_older[i][j] <= 1'b1;
                end
            end
        end
    end

    // A slot is oldest if no other eligible slot is older than it.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            o_oldest[i] = i_elig[i];
            for (int j = 0; j < N; j++) begin
                if (i_elig[j] && r_older[j][i]) o_oldest[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/wakeup_reservation_station.sv
// Out-of-order reservation station: tag-matched CDB wakeup, oldest-ready select to one functional unit.
// Latency: dispatch with all sources ready -> issue_valid_o next cycle; wakeup -> eligible next cycle.
// Backpressure: disp_ready_o low when all slots are valid (registered only); issue holds until issue_ready_i.
// Ports: clock_i/reset_i (async high), flush_i; disp_* dispatch request with per-source rdy/tag/data;
//        cdb_* broadcast lanes; issue_* selected instruction with valid/ready; occupancy_o valid count.
module wakeup_reservation_station
    import rs_pkg::*;
#(
    parameter  int NUM_ENTRIES = RS_NUM_ENTRIES,
    parameter  int NUM_CDB     = RS_NUM_CDB,
    localparam int NUM_SRC     = RS_NUM_SRC,
    localparam int DATA_W      = RS_DATA_W,
    localparam int TAG_W       = RS_TAG_W,
    localparam int PAYLOAD_W   = RS_PAYLOAD_W,
    localparam int IDX_W       = idx_w(NUM_ENTRIES)
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic                      flush_i,
    input  logic                      disp_valid_i,
    output logic                      disp_ready_o,
    input  logic [PAYLOAD_W-1:0]      disp_payload_i,
    input  logic [TAG_W-1:0]          disp_dst_tag_i,
    input  logic [NUM_SRC-1:0]        disp_src_rdy_i,
    input  logic [NUM_SRC*TAG_W-1:0]  disp_src_tag_i,
    input  logic [NUM_SRC*DATA_W-1:0] disp_src_data_i,
    input  logic [NUM_CDB-1:0]        cdb_valid_i,
    input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag_i,
    input  logic [NUM_CDB*DATA_W-1:0] cdb_data_i,
    output logic                      issue_valid_o,
    input  logic                      issue_ready_i,
    output logic [PAYLOAD_W-1:0]      issue_payload_o,
    output logic [TAG_W-1:0]          issue_dst_tag_o,
    output logic [NUM_SRC*DATA_W-1:0] issue_src_data_o,
    output logic [IDX_W:0]            occupancy_o
);

    rs_entry_t r_ent     [NUM_ENTRIES];
    rs_entry_t w_ent_nxt [NUM_ENTRIES];
    logic [IDX_W:0] r_occ;

    logic [NUM_ENTRIES-1:0] w_valid, w_elig, w_oldest, w_alloc, w_alloc_fire, w_free;
    logic                   w_disp_fire, w_issue_fire;
    // {hit, data} per slot/source from the CDB lanes.
    logic [DATA_W:0]        w_wake [NUM_ENTRIES][NUM_SRC];

    // Lowest lane wins: scan high to low so the lowest match is written last.
    function automatic logic [DATA_W:0] cdb_lookup(input tag_t t);
        logic [DATA_W:0] res;
        res = '0;
        for (int l = NUM_CDB - 1; l >= 0; l--) begin
            if (cdb_valid_i[l] && cdb_tag_i[l*TAG_W +: TAG_W] == t)
                res = {1'b1, cdb_data_i[l*DATA_W +: DATA_W]};
        end
        return res;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_valid[i] = r_ent[i].valid;
            w_elig[i]  = r_ent[i].valid & (&r_ent[i].src_rdy);
        end
    end

    // Isolate the lowest clear bit of the valid vector; zero when full.
    assign w_alloc      = ~w_valid & (w_valid + 1'b1);
    assign disp_ready_o = ~(&w_valid);
    assign w_disp_fire  = disp_valid_i & disp_ready_o & ~flush_i;
    assign w_alloc_fire = w_alloc & {NUM_ENTRIES{w_disp_fire}};

    assign issue_valid_o = |w_elig;
    assign w_issue_fire  = issue_valid_o & issue_ready_i & ~flush_i;
    assign w_free        = w_oldest & {NUM_ENTRIES{w_issue_fire}};

    rs_age_matrix #(.N(NUM_ENTRIES)) u_age (
        .i_clock  (clock_i),
        .i_reset  (reset_i),
        .i_alloc  (w_alloc_fire),
        .i_free   (w_free),
        .i_valid  (w_valid),
        .i_elig   (w_elig),
        .o_oldest (w_oldest)
    );

    // A slot being written this cycle snoops with the incoming tags (same-cycle capture).
    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_ent
        for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
            assign w_wake[g][s] = cdb_lookup(w_alloc_fire[g] ? disp_src_tag_i[s*TAG_W +: TAG_W]
                                                             : r_ent[g].src_tag[s]);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_ent_nxt[i] = r_ent[i];
            if (w_alloc_fire[i]) begin
                w_ent_nxt[i].valid    = 1'b1;
                w_ent_nxt[i].payload  = disp_payload_i;
                w_ent_nxt[i].dst_tag  = disp_dst_tag_i;
                w_ent_nxt[i].src_rdy  = disp_src_rdy_i;
                w_ent_nxt[i].src_tag  = disp_src_tag_i;
                w_ent_nxt[i].src_data = disp_src_data_i;
            end else if (w_free[i]) begin
                w_ent_nxt[i].valid = 1'b0;
            end
            for (int s = 0; s < NUM_SRC; s++) begin
                if (w_ent_nxt[i].valid && !w_ent_nxt[i].src_rdy[s] && w_wake[i][s][DATA_W]) begin
                    w_ent_nxt[i].src_rdy[s]  = 1'b1;
                    w_ent_nxt[i].src_data[s] = w_wake[i][s][DATA_W-1:0];
                end
            end
            if (flush_i) w_ent_nxt[i].valid = 1'b0;
        end
    end

    // One-hot select: OR of the chosen slot gives zeros when nothing is eligible.
    always_comb begin
        issue_payload_o  = '0;
        issue_dst_tag_o  = '0;
        issue_src_data_o = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (w_oldest[i]) begin
                issue_payload_o  = issue_payload_o  | r_ent[i].payload;
                issue_dst_tag_o  = issue_dst_tag_o  | r_ent[i].dst_tag;
                issue_src_data_o = issue_src_data_o | r_ent[i].src_data;
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_ENTRIES; i++) r_ent[i] <= '0;
            r_occ <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) r_ent[i] <= w_ent_nxt[i];
            if (flush_i) begin
                r_occ <= '0;
            end else begin
                case ({w_disp_fire, w_issue_fire})
                    2'b10:   r_occ <= r_occ + 1'b1;
                    2'b01:   r_occ <= r_occ - 1'b1;
                    default: r_occ <= r_occ;
                endcase
            end
        end
    end

    assign occupancy_o = r_occ;

endmodule
